// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, bit positions and shared constants for coprocessor 0
package cp0_pkg;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
endpackage

// File: rtl/cp0_if.sv
// cp0_if: mfc0/mtc0/eret bus between the pipeline and coprocessor 0
interface cp0_if;
  logic [4:0]  a;
  logic [31:0] din;
  logic        we;
  logic        eret;
  logic [31:0] pc_next;
  logic [31:0] dout;
  logic [31:0] epc;
  logic        int_req;
  modport master (output a, din, we, eret, pc_next, input dout, epc, int_req);
  modport slave  (input a, din, we, eret, pc_next, output dout, epc, int_req);
endinterface

// File: rtl/cp0_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-low clear
module sync2 #(parameter int W = 6) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  // first stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/cp0.sv
// cp0: SR/Cause/EPC/PRId registers, hardware interrupt request and eret return address
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_3004
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hwint,
  cp0_if.slave       bus
);
  logic [5:0]  im, ip;
  logic        exl, ie;
  logic [4:0]  exc_code;
  logic [31:0] epc_q, sr, cause;
  sync2 #(.W(6)) u_sync (.clk(clk), .reset(reset), .d(hwint), .q(ip));
  assign sr      = {16'b0, im, 8'b0, exl, ie};
  assign cause   = {16'b0, ip, 3'b0, exc_code, 2'b0};
  assign bus.int_req = ie & ~exl & |(ip & im);
  assign bus.epc = epc_q;
  assign bus.dout = bus.a == CP0_SR    ? sr    :
                    bus.a == CP0_CAUSE ? cause :
                    bus.a == CP0_EPC   ? epc_q :
                    bus.a == CP0_PRID  ? PRID  : 32'b0;
  // later assignments win: mtc0, then eret clears EXL, then interrupt entry overrides both
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      exc_code <= '0;
      epc_q    <= '0;
    end else begin
      if (bus.we && bus.a == CP0_SR) begin
        im  <= bus.din[SR_IM_LO +: 6];
        exl <= bus.din[SR_EXL];
        ie  <= bus.din[SR_IE];
      end
      if (bus.we && bus.a == CP0_EPC) epc_q <= {bus.din[31:2], 2'b00};
      if (bus.eret) exl <= 1'b0;
      if (bus.int_req) begin
        exl      <= 1'b1;
        epc_q    <= {bus.pc_next[31:2], 2'b00};
        exc_code <= EXC_INT;
      end
    end
endmodule
